pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register carrying PC, instruction and side payload.
// Optional stall/bubble performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int unsigned DATA_W   = 64,
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter bit          SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [31:0]       r_out_pc;
  logic [31:0]       r_out_instr;
  logic [DATA_W-1:0] r_out_data;
  logic [31:0]       r_skid_pc;
  logic [31:0]       r_skid_instr;
  logic [DATA_W-1:0] r_skid_data;

  logic w_in_ready;
  logic w_accept;
  logic w_retire;
  logic w_load_in;
  logic w_load_skid;
  logic w_pop_skid;
  logic w_clear_main;

  // With the skid buffer in_ready comes from a flop; without it, it looks through to out_ready.
  always_comb begin
    if (SKID) begin
      w_in_ready = r_in_ready & ~reset;
    end else begin
      w_in_ready = ~reset & (~r_out_valid | out_ready);
    end
  end

  // An input offered during a flush is dropped regardless of in_ready.
  assign w_accept = in_valid & w_in_ready & ~flush;
  assign w_retire = r_out_valid & out_ready;

  // Next-state and datapath load selection
  always_comb begin
    w_state_nxt  = r_state;
    w_load_in    = 1'b0;
    w_load_skid  = 1'b0;
    w_pop_skid   = 1'b0;
    w_clear_main = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_in   = 1'b1;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_accept && w_retire) begin
          w_state_nxt = ST_ONE;
          w_load_in   = 1'b1;
        end else if (w_accept) begin
          if (SKID) begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end else if (w_retire) begin
          w_state_nxt  = ST_EMPTY;
          w_clear_main = 1'b1;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_FULL: begin
        if (w_retire) begin
          w_state_nxt = ST_ONE;
          w_pop_skid  = 1'b1;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt  = ST_EMPTY;
        w_clear_main = 1'b1;
      end
    endcase
  end

  // State, handshake flags and main/skid entry registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_pc     <= PC_RESET;
      r_out_instr  <= 32'h0000_0000;
      r_out_data   <= {DATA_W{1'b0}};
      r_skid_pc    <= 32'h0000_0000;
      r_skid_instr <= 32'h0000_0000;
      r_skid_data  <= {DATA_W{1'b0}};
    end else if (flush) begin
      r_state      <= ST_EMPTY;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_instr  <= 32'h0000_0000;
      r_out_data   <= {DATA_W{1'b0}};
      r_skid_pc    <= 32'h0000_0000;
      r_skid_instr <= 32'h0000_0000;
      r_skid_data  <= {DATA_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_in_ready  <= (w_state_nxt != ST_FULL);
      if (w_load_in) begin
        r_out_pc    <= in_pc;
        r_out_instr <= in_instr;
        r_out_data  <= in_data;
      end else if (w_pop_skid) begin
        r_out_pc    <= r_skid_pc;
        r_out_instr <= r_skid_instr;
        r_out_data  <= r_skid_data;
      end else if (w_clear_main) begin
        r_out_instr <= 32'h0000_0000;
        r_out_data  <= {DATA_W{1'b0}};
      end else begin
        r_out_instr <= r_out_instr;
        r_out_data  <= r_out_data;
      end
      if (w_load_skid) begin
        r_skid_pc    <= in_pc;
        r_skid_instr <= in_instr;
        r_skid_data  <= in_data;
      end else if (w_pop_skid) begin
        r_skid_pc    <= 32'h0000_0000;
        r_skid_instr <= 32'h0000_0000;
        r_skid_data  <= {DATA_W{1'b0}};
      end else begin
        r_skid_pc <= r_skid_pc;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_instr = r_out_instr;
  assign out_data  = r_out_data;
  assign occupancy = r_state;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Saturating stall/bubble counters; flush deliberately leaves them running.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= 32'h0000_0000;
      r_bubble_cnt <= 32'h0000_0000;
    end else begin
      if (r_out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (!r_out_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance and one single-register instance.
// Inputs change just after the falling edge; outputs are checked there too.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          reset;
  logic          flush;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0]   s_in_pc, s_in_instr, s_out_pc, s_out_instr;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [1:0]    s_occ;

  logic          n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [31:0]   n_in_pc, n_in_instr, n_out_pc, n_out_instr;
  logic [DW-1:0] n_in_data, n_out_data;
  logic [1:0]    n_occ;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   s_stall, s_bubble, n_stall, n_bubble;
`endif

  int n_pass;
  int n_fail;
  int n_total;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_pc(s_in_pc), .in_instr(s_in_instr), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_pc(s_out_pc), .out_instr(s_out_instr), .out_data(s_out_data),
    .occupancy(s_occ)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(s_stall), .bubble_cnt(s_bubble)
`endif
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_pc(n_in_pc), .in_instr(n_in_instr), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_pc(n_out_pc), .out_instr(n_out_instr), .out_data(n_out_data),
    .occupancy(n_occ)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(n_stall), .bubble_cnt(n_bubble)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv_s(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic [DW-1:0] d);
    s_in_valid = v; s_in_pc = pc; s_in_instr = ins; s_in_data = d;
  endtask

  task automatic drv_n(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic [DW-1:0] d);
    n_in_valid = v; n_in_pc = pc; n_in_instr = ins; n_in_data = d;
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    reset = 1'b1; flush = 1'b0;
    drv_s(1'b0, 32'h0, 32'h0, 16'h0); s_out_ready = 1'b0;
    drv_n(1'b0, 32'h0, 32'h0, 16'h0); n_out_ready = 1'b0;

    // reset: two cycles
    @(negedge clk);
    chk("rst_s_in_ready", s_in_ready, 1'b0);
    chk("rst_n_in_ready", n_in_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0; #1;
    chk("post_rst_s_in_ready", s_in_ready, 1'b1);
    chk("post_rst_s_out_valid", s_out_valid, 1'b0);
    chk("post_rst_s_out_pc", s_out_pc, 32'h0000_3000);
    chk("post_rst_s_out_instr", s_out_instr, 32'h0);
    chk("post_rst_s_out_data", s_out_data, 16'h0);
    chk("post_rst_s_occ", s_occ, 2'd0);
    chk("post_rst_n_in_ready", n_in_ready, 1'b1);
    chk("post_rst_n_out_valid", n_out_valid, 1'b0);

    // streaming at full throughput
    s_out_ready = 1'b1;
    drv_s(1'b1, 32'h3000, 32'h2001_0001, 16'hA000);
    @(negedge clk);
    chk("st0_valid", s_out_valid, 1'b1);
    chk("st0_pc", s_out_pc, 32'h3000);
    chk("st0_instr", s_out_instr, 32'h2001_0001);
    chk("st0_data", s_out_data, 16'hA000);
    chk("st0_occ", s_occ, 2'd1);
    chk("st0_in_ready", s_in_ready, 1'b1);
    drv_s(1'b1, 32'h3004, 32'h2001_0002, 16'hA004);
    @(negedge clk);
    chk("st1_pc", s_out_pc, 32'h3004);
    chk("st1_instr", s_out_instr, 32'h2001_0002);
    chk("st1_in_ready", s_in_ready, 1'b1);
    drv_s(1'b1, 32'h3008, 32'h2001_0003, 16'hA008);
    @(negedge clk);
    chk("st2_pc", s_out_pc, 32'h3008);
    chk("st2_data", s_out_data, 16'hA008);
    chk("st2_occ", s_occ, 2'd1);
    drv_s(1'b0, 32'h0, 32'h0, 16'h0);
    @(negedge clk);
    chk("st3_valid", s_out_valid, 1'b0);
    chk("st3_instr_bubble", s_out_instr, 32'h0);
    chk("st3_data_bubble", s_out_data, 16'h0);
    chk("st3_pc_kept", s_out_pc, 32'h3008);
    chk("st3_occ", s_occ, 2'd0);

    // fill both entries under back-pressure, then drain
    s_out_ready = 1'b0;
    drv_s(1'b1, 32'h3000, 32'h8C01_0000, 16'hB000);
    @(negedge clk);
    chk("fill1_occ", s_occ, 2'd1);
    chk("fill1_in_ready", s_in_ready, 1'b1);
    drv_s(1'b1, 32'h3004, 32'h8C01_0004, 16'hB004);
    @(negedge clk);
    chk("fill2_occ", s_occ, 2'd2);
    chk("fill2_in_ready", s_in_ready, 1'b0);
    chk("fill2_pc", s_out_pc, 32'h3000);
    drv_s(1'b1, 32'h3010, 32'h8C01_0010, 16'hB010);
    @(negedge clk);
    chk("hold_occ", s_occ, 2'd2);
    chk("hold_pc", s_out_pc, 32'h3000);
    chk("hold_instr", s_out_instr, 32'h8C01_0000);
    chk("hold_data", s_out_data, 16'hB000);
    drv_s(1'b0, 32'h0, 32'h0, 16'h0);
    s_out_ready = 1'b1;
    @(negedge clk);
    chk("drain1_pc", s_out_pc, 32'h3004);
    chk("drain1_instr", s_out_instr, 32'h8C01_0004);
    chk("drain1_data", s_out_data, 16'hB004);
    chk("drain1_occ", s_occ, 2'd1);
    chk("drain1_in_ready", s_in_ready, 1'b1);
    @(negedge clk);
    chk("drain2_valid", s_out_valid, 1'b0);
    chk("drain2_occ", s_occ, 2'd0);

    // flush while full, with an input offered
    s_out_ready = 1'b0;
    drv_s(1'b1, 32'h3000, 32'h1000_0000, 16'hC000);
    @(negedge clk);
    drv_s(1'b1, 32'h3004, 32'h1000_0004, 16'hC004);
    @(negedge clk);
    chk("pre_flush_occ", s_occ, 2'd2);
    flush = 1'b1;
    drv_s(1'b1, 32'h300C, 32'h1000_000C, 16'hC00C);
    @(negedge clk);
    flush = 1'b0;
    drv_s(1'b0, 32'h0, 32'h0, 16'h0);
    s_out_ready = 1'b1;
    chk("flush_valid", s_out_valid, 1'b0);
    chk("flush_instr", s_out_instr, 32'h0);
    chk("flush_data", s_out_data, 16'h0);
    chk("flush_occ", s_occ, 2'd0);
    chk("flush_in_ready", s_in_ready, 1'b1);
    @(negedge clk);
    chk("flush_no_300c", s_out_valid, 1'b0);

    // flush with one entry held and in_ready high: input still discarded
    s_out_ready = 1'b0;
    drv_s(1'b1, 32'h3014, 32'h1000_0014, 16'hC014);
    @(negedge clk);
    chk("flush1_occ", s_occ, 2'd1);
    flush = 1'b1;
    drv_s(1'b1, 32'h3018, 32'h1000_0018, 16'hC018);
    #1;
    chk("flush1_in_ready", s_in_ready, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    drv_s(1'b0, 32'h0, 32'h0, 16'h0);
    chk("flush1_valid", s_out_valid, 1'b0);
    chk("flush1_occ_after", s_occ, 2'd0);
    chk("flush1_pc_kept", s_out_pc, 32'h3014);
    @(negedge clk);
    chk("flush1_no_3018", s_out_valid, 1'b0);

    // single-register variant: combinational in_ready
    n_out_ready = 1'b0;
    drv_n(1'b1, 32'h4000, 32'h0800_1000, 16'hD000);
    @(negedge clk);
    #1;
    chk("ns_valid", n_out_valid, 1'b1);
    chk("ns_pc", n_out_pc, 32'h4000);
    chk("ns_occ", n_occ, 2'd1);
    chk("ns_in_ready_stall", n_in_ready, 1'b0);
    drv_n(1'b1, 32'h4004, 32'h0800_1001, 16'hD004);
    @(negedge clk);
    chk("ns_hold_pc", n_out_pc, 32'h4000);
    chk("ns_hold_instr", n_out_instr, 32'h0800_1000);
    chk("ns_hold_occ", n_occ, 2'd1);
    n_out_ready = 1'b1;
    #1;
    chk("ns_in_ready_comb", n_in_ready, 1'b1);
    @(negedge clk);
    chk("ns_swap_pc", n_out_pc, 32'h4004);
    chk("ns_swap_instr", n_out_instr, 32'h0800_1001);
    chk("ns_swap_data", n_out_data, 16'hD004);
    chk("ns_swap_occ", n_occ, 2'd1);
    chk("ns_swap_valid", n_out_valid, 1'b1);
    drv_n(1'b0, 32'h0, 32'h0, 16'h0);
    @(negedge clk);
    chk("ns_empty_valid", n_out_valid, 1'b0);
    chk("ns_empty_occ", n_occ, 2'd0);
    chk("ns_empty_instr", n_out_instr, 32'h0);

`ifdef PIPE_STAGE_PERF_EN
    // counters: 1 bubble, 5 stalls, retire, 3 bubbles, then a flush cycle
    reset = 1'b1;
    s_out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("perf_rst_stall", s_stall, 32'd0);
    chk("perf_rst_bubble", s_bubble, 32'd0);
    drv_s(1'b1, 32'h3020, 32'h1111_0000, 16'hE000);
    @(negedge clk);
    drv_s(1'b0, 32'h0, 32'h0, 16'h0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("perf_stall5", s_stall, 32'd5);
    chk("perf_bubble1", s_bubble, 32'd1);
    s_out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("perf_stall_after", s_stall, 32'd5);
    chk("perf_bubble4", s_bubble, 32'd4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("perf_flush_stall", s_stall, 32'd5);
    chk("perf_flush_bubble", s_bubble, 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
